vga_pixel_sink: RTL and testbench
=================================

Name: vga_pixel_sink

Overview:
- Receiving end of the pixel-write bus driven by the drawing objects (x, y, color, write strobe).
- Accepts one pixel per cycle with no backpressure on the producer, clips off-screen coordinates, and buffers accepted pixels in a small FIFO.
- Drains the FIFO into the framebuffer write port using a ready/valid handshake.
- Provides a whole-screen clear sequence.
- Sits between the drawing-object mux and the video-memory controller.

Parameters:
- nX, 10, x coordinate width
- nY, 9, y coordinate width
- COLOR_DEPTH, 9, pixel color width
- XSCREEN, 640, visible width
- YSCREEN, 480, visible height
- ADDR_W, 19, framebuffer address width
- FIFO_DEPTH, 8, entries; power of two
- CLEAR_COLOR, 9'b000_000_000, fill color for clear
- KEY_COLOR, 9'b111_000_111, transparent color (optional feature only)

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- pix_x  in  nX  pixel x
- pix_y  in  nY  pixel y
- pix_color  in  COLOR_DEPTH  pixel color
- pix_write  in  1  pixel valid, one pixel per cycle
- clear_req  in  1  start screen clear; level sampled
- clear_busy  out  1  clear in progress
- mem_addr  out  ADDR_W  framebuffer address
- mem_data  out  COLOR_DEPTH  framebuffer write data
- mem_wren  out  1  write valid
- mem_ready  in  1  memory accepts the write this cycle
- fifo_level  out  4  occupied entries, 0..FIFO_DEPTH
- drop_count  out  16  pixels lost to FIFO overflow, saturating
- clip_count  out  16  off-screen pixels discarded, saturating

Behaviour:
- Reset (async, Reset=1): FIFO empty, state IDLE.
  - All outputs 0: mem_addr, mem_data, mem_wren, clear_busy, fifo_level, drop_count, clip_count.
- Stage 1, registered every cycle:
  - If pix_write=1 and pix_x<XSCREEN and pix_y<YSCREEN: compute addr = pix_y*XSCREEN + pix_x at ADDR_W width (max 307199); stage valid.
  - If pix_write=1 and off-screen: discard and increment clip_count.
- Stage 2 (FIFO push):
  - A valid stage-1 entry is pushed unless the FIFO is full and no pop occurs in the same cycle.
  - Otherwise it is dropped and drop_count increments.
  - Full FIFO with a simultaneous pop accepts the push; no drop.
- Handshake:
  - While mem_wren=1, mem_addr and mem_data hold stable until a cycle with mem_ready=1; that cycle is the transfer.
  - mem_ready is ignored while mem_wren=0.
- Latency: pixel at cycle N with empty FIFO, IDLE, mem_ready=1 → mem_wren=1 with its data at cycle N+2, transfer at N+2.
- Back-to-back: on a transfer, if the FIFO is non-empty the next entry is loaded the same edge, so mem_wren stays high. Sustained throughput is 1 pixel/cycle.
- FSM:
  - IDLE: mem_wren=0.
    - clear_req=1 → CLEAR, with the clear counter set to 0.
    - Otherwise, FIFO non-empty → DRAIN, loading the head entry.
  - DRAIN: mem_wren=1.
    - On a transfer: if clear_req=1 → CLEAR; else if FIFO non-empty, load the next entry and stay; else → IDLE.
    - clear_req never aborts a pending (unaccepted) write.
  - CLEAR: clear_busy=1, mem_wren=1, mem_data=CLEAR_COLOR, mem_addr=counter.
    - Counter increments on each transfer.
    - Transfer at addr XSCREEN*YSCREEN-1 → IDLE; clear_busy falls the following cycle.
    - FIFO is not popped during CLEAR; pushes continue, with overflow counted as drops.
    - clear_req while in CLEAR is ignored.
- fifo_level reflects the post-edge occupancy; the entry held on the memory port is not counted.
- Counters saturate at 16'hFFFF; no wrap.
- Reset asserted mid-CLEAR or mid-DRAIN aborts immediately; there is no partial-write guarantee.

Optional Feature:
- Macro VGA_SINK_COLOR_KEY_EN.
- Defined: an on-screen pixel with pix_color==KEY_COLOR is discarded at stage 1. It is not pushed and not counted in clip_count or drop_count, which lets ROM sprites carry transparent pixels.
- Undefined: KEY_COLOR is unused and all on-screen pixels are written.

Test Plan:
- Reset, then a single pixel x=10, y=2, color=9'h1FF with mem_ready=1 → at cycle N+2, mem_wren=1, mem_addr=1290, mem_data=9'h1FF; then IDLE.
- Pixels at (640,0) and (0,480) → no mem_wren; clip_count=2.
- 12 consecutive pixels with mem_ready=0 → fifo_level=8, one entry held on the port, drop_count=3. Then mem_ready=1 → 9 transfers in order, back-to-back.
- clear_req pulse with mem_ready=1 → exactly 307200 transfers, addr 0..307199, data 0; clear_busy high throughout, low afterwards. A pixel written mid-clear appears after the last clear write.
- mem_ready toggling 1,0,1,0 during DRAIN → addr/data stable on the 0 cycles; no duplicated or skipped entries.
- With VGA_SINK_COLOR_KEY_EN defined, pixel color=9'b111_000_111 at (5,5) → no write, all counters 0. With the macro undefined → write at addr 3205.

Source files
------------

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink
// Receiving end of the drawing-object pixel bus. Clips off-screen pixels,
// buffers accepted ones in a small FIFO and drains them to the framebuffer
// write port over a ready/valid handshake. Also runs a whole-screen clear.
//
// Optional build macro: VGA_SINK_COLOR_KEY_EN
//   When defined, on-screen pixels whose color equals KEY_COLOR are treated
//   as transparent and silently discarded at stage 1.

module vga_pixel_sink #(
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9,
  parameter int XSCREEN     = 640,
  parameter int YSCREEN     = 480,
  parameter int ADDR_W      = 19,
  parameter int FIFO_DEPTH  = 8,
  parameter logic [COLOR_DEPTH-1:0] CLEAR_COLOR = 9'b000_000_000,
  parameter logic [COLOR_DEPTH-1:0] KEY_COLOR   = 9'b111_000_111
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [nX-1:0]          pix_x,
  input  logic [nY-1:0]          pix_y,
  input  logic [COLOR_DEPTH-1:0] pix_color,
  input  logic                   pix_write,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [COLOR_DEPTH-1:0] mem_data,
  output logic                   mem_wren,
  input  logic                   mem_ready,
  output logic [3:0]             fifo_level,
  output logic [15:0]            drop_count,
  output logic [15:0]            clip_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int XW    = nX + 1;
  localparam int YW    = nY + 1;

  localparam logic [XW-1:0]     X_LIMIT    = XW'(XSCREEN);
  localparam logic [YW-1:0]     Y_LIMIT    = YW'(YSCREEN);
  localparam logic [ADDR_W-1:0] X_STRIDE   = ADDR_W'(XSCREEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(XSCREEN * YSCREEN - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

  state_t state, next_state;

  logic                   s1_valid;
  logic [ADDR_W-1:0]      s1_addr;
  logic [COLOR_DEPTH-1:0] s1_color;

  logic [ADDR_W-1:0]      fifo_addr  [FIFO_DEPTH];
  logic [COLOR_DEPTH-1:0] fifo_color [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       fifo_count;

  logic [ADDR_W-1:0]      port_addr;
  logic [COLOR_DEPTH-1:0] port_color;
  logic [ADDR_W-1:0]      clear_addr;
  logic [15:0]            drop_cnt, clip_cnt;

  logic on_screen, key_hit, accept_pixel;
  logic fifo_empty, fifo_full, transfer;
  logic load, clear_start, pop, bypass, push, drop;

  assign on_screen = ({1'b0, pix_x} < X_LIMIT) && ({1'b0, pix_y} < Y_LIMIT);

`ifdef VGA_SINK_COLOR_KEY_EN
  assign key_hit = (pix_color == KEY_COLOR);
`else
  assign key_hit = 1'b0 && (pix_color == KEY_COLOR);
`endif

  assign accept_pixel = pix_write && on_screen && !key_hit;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign mem_wren   = (state != IDLE);
  assign transfer   = mem_wren && mem_ready;

  // An empty FIFO lets the stage-1 pixel go straight to the port, which is
  // what gives the two-cycle latency and one-pixel-per-cycle throughput.
  assign pop    = load && !fifo_empty;
  assign bypass = load && fifo_empty;
  assign push   = s1_valid && !bypass && (!fifo_full || pop);
  assign drop   = s1_valid && !bypass && fifo_full && !pop;

  // Stage 1: clip, compute the linear address and count off-screen pixels.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_color <= '0;
      clip_cnt <= '0;
    end else begin
      s1_valid <= accept_pixel;
      if (accept_pixel) begin
        s1_addr  <= ADDR_W'(pix_y) * X_STRIDE + ADDR_W'(pix_x);
        s1_color <= pix_color;
      end
      if (pix_write && !on_screen && (clip_cnt != 16'hFFFF))
        clip_cnt <= clip_cnt + 16'd1;
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= s1_addr;
      fifo_color[wr_ptr] <= s1_color;
    end
  end

  // FIFO pointers, occupancy and the saturating overflow counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Drain FSM next-state logic; a pending write is never abandoned for a clear.
  always_comb begin
    next_state  = state;
    load        = 1'b0;
    clear_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          next_state  = CLEAR;
          clear_start = 1'b1;
        end else if (!fifo_empty || s1_valid) begin
          next_state = DRAIN;
          load       = 1'b1;
        end
      end
      DRAIN: begin
        if (transfer) begin
          if (clear_req) begin
            next_state  = CLEAR;
            clear_start = 1'b1;
          end else if (!fifo_empty || s1_valid) begin
            load = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      CLEAR: begin
        if (transfer && (clear_addr == LAST_ADDR))
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Memory port holding register and the clear address counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      port_addr  <= '0;
      port_color <= '0;
      clear_addr <= '0;
    end else begin
      if (load) begin
        port_addr  <= fifo_empty ? s1_addr  : fifo_addr[rd_ptr];
        port_color <= fifo_empty ? s1_color : fifo_color[rd_ptr];
      end
      if (clear_start)
        clear_addr <= '0;
      else if ((state == CLEAR) && transfer)
        clear_addr <= clear_addr + 1'b1;
    end
  end

  assign clear_busy = (state == CLEAR);
  assign mem_addr   = (state == CLEAR) ? clear_addr  : port_addr;
  assign mem_data   = (state == CLEAR) ? CLEAR_COLOR : port_color;
  assign fifo_level = 4'(fifo_count);
  assign drop_count = drop_cnt;
  assign clip_count = clip_cnt;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// tb_vga_pixel_sink
// Randomised and directed stimulus for vga_pixel_sink, checked every cycle
// against a queue-based behavioural model. A reduced screen keeps the clear
// sequence short.

module tb_vga_pixel_sink;

  localparam int XS         = 40;
  localparam int YS         = 30;
  localparam int SCREEN_PIX = XS * YS;
  localparam int DEPTH      = 8;
  localparam int KEY        = 9'b111_000_111;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic [8:0]  pix_color = '0;
  logic        pix_write = 1'b0;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic [18:0] mem_addr;
  logic [8:0]  mem_data;
  logic        mem_wren;
  logic        mem_ready = 1'b0;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;
  logic [15:0] clip_count;

  int check_count = 0;
  int err_count   = 0;
  int dut_xfers   = 0;
  int dut_clear_writes = 0;

  // Behavioural model state: what sits on the port, what waits behind it.
  bit m_clearing = 0;
  int m_clear_idx = 0;
  bit m_on_port = 0;
  int m_port_addr = 0;
  int m_port_color = 0;
  int fq_addr[$];
  int fq_color[$];
  bit m_stage_valid = 0;
  int m_stage_addr = 0;
  int m_stage_color = 0;
  int m_drops = 0;
  int m_clips = 0;

  vga_pixel_sink #(
    .XSCREEN(XS),
    .YSCREEN(YS)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_color(pix_color),
    .pix_write(pix_write),
    .clear_req(clear_req),
    .clear_busy(clear_busy),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_wren(mem_wren),
    .mem_ready(mem_ready),
    .fifo_level(fifo_level),
    .drop_count(drop_count),
    .clip_count(clip_count)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model's view of the current cycle.
  task automatic compareModel();
    bit wren_exp;
    wren_exp = m_clearing || m_on_port;
    checkOutput("wren", 32'(mem_wren), 32'(wren_exp));
    checkOutput("busy", 32'(clear_busy), 32'(m_clearing));
    if (wren_exp) begin
      checkOutput("addr", 32'(mem_addr), m_clearing ? m_clear_idx : m_port_addr);
      checkOutput("data", 32'(mem_data), m_clearing ? 0 : m_port_color);
    end
    checkOutput("level", 32'(fifo_level), fq_addr.size());
    checkOutput("drops", 32'(drop_count), m_drops);
    checkOutput("clips", 32'(clip_count), m_clips);
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic modelStep(input int x, input int y, input int c, input bit w,
                           input bit clr, input bit rdy);
    bit xfer;
    bit load;
    bit bypass;
    bit have_work;
    xfer   = (m_clearing || m_on_port) && rdy;
    load   = 0;
    bypass = 0;
    have_work = (fq_addr.size() > 0) || m_stage_valid;
    if (m_clearing) begin
      if (xfer) begin
        if (m_clear_idx == SCREEN_PIX - 1) m_clearing = 0;
        else m_clear_idx++;
      end
    end else if (!m_on_port) begin
      if (clr) begin
        m_clearing = 1;
        m_clear_idx = 0;
      end else if (have_work) begin
        load = 1;
      end
    end else if (xfer) begin
      m_on_port = 0;
      if (clr) begin
        m_clearing = 1;
        m_clear_idx = 0;
      end else if (have_work) begin
        load = 1;
      end
    end
    if (load) begin
      m_on_port = 1;
      if (fq_addr.size() > 0) begin
        m_port_addr  = fq_addr.pop_front();
        m_port_color = fq_color.pop_front();
      end else begin
        m_port_addr  = m_stage_addr;
        m_port_color = m_stage_color;
        bypass = 1;
      end
    end
    if (m_stage_valid && !bypass) begin
      if (fq_addr.size() < DEPTH) begin
        fq_addr.push_back(m_stage_addr);
        fq_color.push_back(m_stage_color);
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
    m_stage_valid = 0;
    if (w) begin
      if (x < XS && y < YS) begin
`ifdef VGA_SINK_COLOR_KEY_EN
        if (c != KEY) begin
          m_stage_valid = 1;
          m_stage_addr  = y * XS + x;
          m_stage_color = c;
        end
`else
        m_stage_valid = 1;
        m_stage_addr  = y * XS + x;
        m_stage_color = c;
`endif
      end else if (m_clips < 65535) begin
        m_clips++;
      end
    end
  endtask

  // One clock cycle: check outputs, drive inputs, step the model.
  task automatic applyStimulus(input int x, input int y, input int c, input bit w,
                               input bit clr, input bit rdy);
    @(negedge Clock);
    compareModel();
    pix_x     = 10'(x);
    pix_y     = 9'(y);
    pix_color = 9'(c);
    pix_write = w;
    clear_req = clr;
    mem_ready = rdy;
    if (mem_wren && mem_ready) begin
      dut_xfers++;
      if (clear_busy) dut_clear_writes++;
    end
    modelStep(x, y, c, w, clr, rdy);
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    int start_xfers;
    $display("[TB] starting vga_pixel_sink bench");

    // Reset values.
    @(negedge Clock);
    checkOutput("rst_wren",  32'(mem_wren), 0);
    checkOutput("rst_busy",  32'(clear_busy), 0);
    checkOutput("rst_addr",  32'(mem_addr), 0);
    checkOutput("rst_data",  32'(mem_data), 0);
    checkOutput("rst_level", 32'(fifo_level), 0);
    checkOutput("rst_drops", 32'(drop_count), 0);
    checkOutput("rst_clips", 32'(clip_count), 0);
    Reset = 1'b0;

    // Single pixel: visible on the port two cycles later.
    applyStimulus(10, 2, 9'h1FF, 1'b1, 1'b0, 1'b1);
    idleCycles(2, 1'b1);
    checkOutput("lat_wren", 32'(mem_wren), 1);
    checkOutput("lat_addr", 32'(mem_addr), 2 * XS + 10);
    checkOutput("lat_data", 32'(mem_data), 9'h1FF);
    idleCycles(3, 1'b1);
    checkOutput("lat_idle", 32'(mem_wren), 0);

    // Clipping on both screen edges.
    applyStimulus(XS, 0, 9'h0AA, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, YS, 9'h055, 1'b1, 1'b0, 1'b1);
    idleCycles(3, 1'b1);
    checkOutput("clip_cnt", 32'(clip_count), 2);
    checkOutput("clip_nowr", 32'(mem_wren), 0);

    // Overflow with a stalled memory, then a back-to-back drain.
    for (int i = 0; i < 12; i++) applyStimulus(i, 5, i + 1, 1'b1, 1'b0, 1'b0);
    idleCycles(2, 1'b0);
    checkOutput("ovf_level", 32'(fifo_level), 8);
    checkOutput("ovf_drops", 32'(drop_count), 3);
    checkOutput("ovf_held",  32'(mem_wren), 1);
    start_xfers = dut_xfers;
    idleCycles(9, 1'b1);
    checkOutput("drain_b2b", dut_xfers - start_xfers, 9);
    idleCycles(3, 1'b1);
    checkOutput("drain_idle", 32'(mem_wren), 0);

    // Whole-screen clear with a pixel injected part-way through.
    applyStimulus(0, 0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < SCREEN_PIX + 8; i++) begin
      if (i == 100) applyStimulus(3, 4, 9'h123, 1'b1, 1'b0, 1'b1);
      else          applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("clear_writes", dut_clear_writes, SCREEN_PIX);
    checkOutput("clear_done", 32'(clear_busy), 0);

    // Ready toggling while draining.
    for (int i = 0; i < 4; i++) applyStimulus(20 + i, 7, 9'h040 + i, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1'b0, 1'b0, (i % 2) == 0);
    idleCycles(4, 1'b1);

    // Key-colored pixel.
    applyStimulus(5, 5, KEY, 1'b1, 1'b0, 1'b1);
    idleCycles(2, 1'b1);
`ifdef VGA_SINK_COLOR_KEY_EN
    checkOutput("key_nowr", 32'(mem_wren), 0);
`else
    checkOutput("key_addr", 32'(mem_addr), 5 * XS + 5);
`endif
    idleCycles(3, 1'b1);

    // Randomised traffic with varying memory availability and one clear.
    for (int i = 0; i < 3000; i++) begin
      int rdy_thresh;
      rdy_thresh = (i < 1000) ? 3 : ((i < 2000) ? 1 : 2);
      applyStimulus(int'($urandom_range(0, XS + 7)), int'($urandom_range(0, YS + 5)),
                    int'($urandom_range(0, 511)), $urandom_range(0, 3) != 0,
                    i == 1500, int'($urandom_range(0, 3)) < rdy_thresh);
    end
    idleCycles(SCREEN_PIX + 30, 1'b1);
    checkOutput("final_idle", 32'(mem_wren), 0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
